// File: rtl/slow_clock_monitor_pkg.sv
// slow_clock_monitor_pkg: shared FSM states, default widths and tolerance-bound helpers
package slow_clock_monitor_pkg;
  localparam int DEF_CNT_W = 16;
  localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2;
  function automatic int tol_lo(input int exp_period, input int tol);
    return (exp_period > tol) ? exp_period - tol : 0;
  endfunction
  function automatic int tol_hi(input int exp_period, input int tol);
    return exp_period + tol;
  endfunction
endpackage

// File: rtl/slow_clock_monitor_if.sv
// slow_clock_monitor_if: slow clock under test plus the measurement/status results
interface slow_clock_monitor_if import slow_clock_monitor_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);
  logic slow_clock;
  logic meas_valid;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W:0] period_cycles;
  logic locked;
  logic stuck;
  modport master (
    output slow_clock,
    input meas_valid, high_cycles, low_cycles, period_cycles, locked, stuck
  );
  modport slave (
    input slow_clock,
    output meas_valid, high_cycles, low_cycles, period_cycles, locked, stuck
  );
endinterface

// File: rtl/slow_clock_monitor_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer with rise/fall pulses from a registered copy
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
  logic [1:0] warm;
  always_ff @(posedge clock)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      warm <= 2'd0;
    end else begin
      s1 <= d;
      s2 <= s1;
      prev <= s2;
      warm <= (warm == 2'd3) ? warm : warm + 2'd1;
    end
  // edges are masked until the pipeline holds real samples, so reset zeros never look like a transition
  assign rise = (warm == 2'd3) & s2 & ~prev;
  assign fall = (warm == 2'd3) & ~s2 & prev;
endmodule

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor: measures high/low/period of a slow clock and reports lock and stuck status
module slow_clock_monitor import slow_clock_monitor_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int EXP_PERIOD = 2000,
  parameter int TOL = 4,
  parameter int LOCK_N = 4,
  parameter int TIMEOUT = 8191
) (
  input logic clock,
  input logic reset,
  slow_clock_monitor_if.slave bus
);
  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W:0] LO = (CNT_W+1)'(tol_lo(EXP_PERIOD, TOL));
  localparam logic [CNT_W:0] HI = (CNT_W+1)'(tol_hi(EXP_PERIOD, TOL));
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);
  localparam logic [IDLE_W-1:0] TO = IDLE_W'(TIMEOUT);
  logic rise, fall, edge_seen, timeout, publish, in_tol;
  logic [1:0] state;
  logic [CNT_W-1:0] hcnt, lcnt;
  logic [CNT_W:0] period;
  logic [RUN_W-1:0] run, run_next;
  logic [IDLE_W-1:0] idle;

  sync_edge_detect u_sync (
    .clock(clock),
    .reset(reset),
    .d(bus.slow_clock),
    .rise(rise),
    .fall(fall)
  );

  always_comb begin
    edge_seen = rise | fall;
    timeout = !edge_seen && idle == TO - 1'b1;
    publish = state == LOW && rise;
    period = {1'b0, hcnt} + {1'b0, lcnt};
    in_tol = period >= LO && period <= HI && hcnt != MAX && lcnt != MAX;
    run_next = !in_tol ? '0 : (run == RUN_MAX) ? run : run + 1'b1;
  end

  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      hcnt <= '0;
      lcnt <= '0;
      run <= '0;
      idle <= '0;
      bus.meas_valid <= 1'b0;
      bus.high_cycles <= '0;
      bus.low_cycles <= '0;
      bus.period_cycles <= '0;
      bus.locked <= 1'b0;
      bus.stuck <= 1'b0;
    end else begin
      bus.meas_valid <= publish;
      idle <= edge_seen ? '0 : (idle == TO) ? idle : idle + 1'b1;
      bus.stuck <= edge_seen ? 1'b0 : timeout ? 1'b1 : bus.stuck;
      if (publish) begin
        bus.high_cycles <= hcnt;
        bus.low_cycles <= lcnt;
        bus.period_cycles <= period;
        run <= run_next;
        bus.locked <= run_next == RUN_MAX;
      end else if (timeout) begin
        run <= '0;
        bus.locked <= 1'b0;
      end
      // a rise while HIGH is impossible after synchronization, so it is taken as the missing fall
      if (timeout)
        state <= IDLE;
      else if (rise && state != HIGH) begin
        state <= HIGH;
        hcnt <= CNT_W'(1);
        lcnt <= '0;
      end else if (edge_seen && state == HIGH) begin
        state <= LOW;
        lcnt <= CNT_W'(1);
      end else if (state == HIGH)
        hcnt <= (hcnt == MAX) ? hcnt : hcnt + 1'b1;
      else if (state == LOW)
        lcnt <= (lcnt == MAX) ? lcnt : lcnt + 1'b1;
    end
endmodule
